serial_in_parallel_out: RTL and testbench
=========================================

// Module: serial_in_parallel_out
// PURPOSE
//  Receive-side companion to the 4-bit parallel-load/serial-shift transmitter in the ALU datapath.
//  Collects an MSB-first serial bit stream, framed by a start marker, into WIDTH-bit words.
//  Presents each completed word on a one-entry valid/ready output register.
//  Flags overrun and framing errors as one-cycle pulses.
// PARAMETERS
//  WIDTH  4  data bits per word; legal range 2..16
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  sin        in   1      serial data bit
//  sin_valid  in   1      sin is sampled on this cycle
//  sin_start  in   1      qualified by sin_valid; marks the current bit as the MSB of a new word
//  dout       out  WIDTH  received word; first bit received is in dout[WIDTH-1]
//  dout_valid out  1      dout holds an unconsumed word
//  dout_ready in   1      consumer accepts dout when dout_valid && dout_ready
//  overrun    out  1      1-cycle pulse: completed word dropped because the holding register was full
//  align_err  out  1      1-cycle pulse: sin_start arrived while a word was partially received
// BEHAVIOUR
//  Reset: all of the following clear asynchronously; nothing is emitted until the next sin_start.
//   - state=IDLE, bit count=0, shift register=0
//   - dout=0, dout_valid=0, overrun=0, align_err=0
//  Only cycles with sin_valid=1 advance state; sin and sin_start are ignored otherwise.
//  FSM states: IDLE, SHIFT, and PAR (PAR exists only with SIPO_PARITY_EN).
//   - IDLE: sin_start=1 -> shift in sin, cnt=1, go to SHIFT. sin_start=0 -> bit discarded (hunting).
//   - SHIFT: shift in sin (sh <= {sh[WIDTH-2:0],sin}) and increment cnt.
//   - SHIFT, sin_start=1: restart. Pulse align_err, drop the partial word, take this bit as the new MSB, cnt=1.
//   - SHIFT, WIDTH-th bit accepted: word complete. Go to IDLE, or to PAR when parity is enabled.
//  Word completion:
//   - Holding register empty, or drained this cycle (dout_valid && dout_ready): load dout.
//     dout_valid=1 on the next cycle.
//   - Otherwise: word dropped, dout unchanged, overrun pulses on the next cycle.
//  Latency: dout_valid rises 1 cycle after the final bit (data bit or parity bit) is accepted.
//  Handshake:
//   - dout and dout_valid stay stable until accepted.
//   - dout_valid falls on the cycle after acceptance unless a new word loads in the same cycle.
//  Back-to-back words: the next word needs a new sin_start; the accepted bit rate is 1 bit/cycle.
//  A completion and an acceptance in the same cycle: accept the old word, load the new one; no overrun.
//  Error pulses are registered and last exactly 1 cycle; they never block reception.
// CONFIGURATION
//  SIPO_PARITY_EN defined:
//   - After WIDTH data bits the FSM enters PAR; the next valid bit is an even-parity bit.
//   - Parity is good when the XOR of data and parity bits is 0: word completes normally.
//   - Parity is bad: word dropped, output port parity_err (out, 1) pulses 1 cycle.
//   - sin_start in PAR is handled as a restart, same as in SHIFT.
//  SIPO_PARITY_EN undefined: no PAR state, no parity_err port; the word completes on its WIDTH-th bit.
// STRUCTURE
//  Package sipo_pkg:
//   - FSM state typedef (IDLE/SHIFT/PAR)
//   - CNT_W = $clog2(WIDTH+1)
//  Sub-module sipo_hold_reg: one-entry valid/ready register (WIDTH data, load/accept, full flag).
//  Top level: FSM, counter, shift register and error pulses.
// TESTING (WIDTH=4)
//  1. Reset mid-word: bits start+1,0 then rst_n=0.
//     -> dout_valid=0; after reset, bits 0,1,1 with no start produce nothing.
//  2. start+1,0,1,1 with dout_ready=1 -> next cycle dout=4'hB, dout_valid=1 for 1 cycle.
//  3. Two words 4'hB then 4'h6, back-to-back, dout_ready=0.
//     -> dout=4'hB held, overrun pulses once; after ready, no second word appears.
//  4. start+1,1, then start+0,1,0,1 -> align_err pulses once; dout=4'h5.
//  5. Word 4'h6 completes in the same cycle the held word 4'hB is accepted.
//     -> no overrun; dout=4'h6 the next cycle.
//  6. [SIPO_PARITY_EN] 1,0,1,1 with parity 1 -> dout=4'hB; with parity 0 -> parity_err pulse, no dout_valid.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out receiver.
package sipo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } sipo_state_e;

  // Bit-counter width for a given word width (CNT_W = $clog2(WIDTH+1)).
  function automatic int sipo_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// One-entry valid/ready holding register; reports a dropped load when full and not draining.
module sipo_hold_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             drop_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             accept;
  logic             load_ok;

  assign accept  = valid_q && ready_i;
  // A draining entry frees the slot in the same cycle a new word arrives.
  assign load_ok = load_i && (!valid_q || ready_i);
  assign drop_o  = load_i && valid_q && !ready_i;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_ok) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign full_o  = valid_q;

endmodule

// File: rtl/serial_in_parallel_out.sv
// MSB-first framed serial receiver with valid/ready word output and error pulses.
// Optional even-parity bit per word when SIPO_PARITY_EN is defined.
module serial_in_parallel_out
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
`ifdef SIPO_PARITY_EN
  output logic             align_err,
  output logic             parity_err
`else
  output logic             align_err
`endif
);

  localparam int CNT_W = sipo_cnt_w(WIDTH);

  sipo_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] sh_shift;
  logic [WIDTH-1:0] word_data;
  logic             word_done;
  logic             align_q, align_d;
  logic             perr_q, perr_d;
  logic             overrun_q;
  logic             drop;
  logic             hold_full;

  assign sh_shift = {sh_q[WIDTH-2:0], sin};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    word_done = 1'b0;
    word_data = sh_shift;
    align_d   = 1'b0;
    perr_d    = 1'b0;
    if (sin_valid) begin
      if (sin_start) begin
        // A start marker always begins a fresh word; mid-word it also flags misalignment.
        align_d = (state_q != ST_IDLE);
        sh_d    = {{(WIDTH-1){1'b0}}, sin};
        cnt_d   = CNT_W'(1);
        state_d = ST_SHIFT;
      end else begin
        case (state_q)
          ST_SHIFT: begin
            sh_d = sh_shift;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
              cnt_d   = CNT_W'(WIDTH);
              state_d = ST_PAR;
`else
              cnt_d     = '0;
              word_done = 1'b1;
              state_d   = ST_IDLE;
`endif
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
`ifdef SIPO_PARITY_EN
          ST_PAR: begin
            cnt_d     = '0;
            state_d   = ST_IDLE;
            word_data = sh_q;
            if ((^sh_q ^ sin) == 1'b0) begin
              word_done = 1'b1;
            end else begin
              perr_d = 1'b1;
            end
          end
`endif
          ST_IDLE: begin
            state_d = ST_IDLE;
          end
          default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      align_q   <= 1'b0;
      perr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      align_q   <= align_d;
      perr_q    <= perr_d;
      overrun_q <= drop;
    end
  end

  sipo_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (word_done),
    .data_i  (word_data),
    .ready_i (dout_ready),
    .data_o  (dout),
    .valid_o (dout_valid),
    .full_o  (hold_full),
    .drop_o  (drop)
  );

  assign overrun   = overrun_q;
  assign align_err = align_q;
`ifdef SIPO_PARITY_EN
  assign parity_err = perr_q;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, hold_full, perr_q};

endmodule

// File: tb/tb_serial_in_parallel_out.sv
// Self-checking bench for serial_in_parallel_out (WIDTH=4), directed scenarios plus random traffic.
module tb_serial_in_parallel_out;

  localparam int WIDTH = 4;
`ifdef SIPO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
  localparam bit PAR   = 1'b1;
`else
  localparam int NBITS = WIDTH;
  localparam bit PAR   = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sin = 1'b0;
  logic             sin_valid = 1'b0;
  logic             sin_start = 1'b0;
  logic             dout_ready = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             overrun;
  logic             align_err;
  logic             parity_err;

  serial_in_parallel_out #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sin_start  (sin_start),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
`ifdef SIPO_PARITY_EN
    .align_err  (align_err),
    .parity_err (parity_err)
`else
    .align_err  (align_err)
`endif
  );

`ifndef SIPO_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: received bits kept as a list, holding slot as a value/flag pair.
  bit               m_part[$];
  bit               m_valid;
  logic [WIDTH-1:0] m_dout;
  bit               m_ovr;
  bit               m_align;
  bit               m_perr;

  function automatic void model_reset();
    m_part.delete();
    m_valid = 1'b0;
    m_dout  = '0;
    m_ovr   = 1'b0;
    m_align = 1'b0;
    m_perr  = 1'b0;
  endfunction

  function automatic void model_step(input bit v, input bit s, input bit st, input bit rdy);
    bit accept;
    bit done;
    int value;
    int ones;
    accept  = m_valid && rdy;
    done    = 1'b0;
    value   = 0;
    ones    = 0;
    m_ovr   = 1'b0;
    m_align = 1'b0;
    m_perr  = 1'b0;
    if (accept) $display("transaction: word 0x%h accepted", m_dout);
    if (v) begin
      if (st) begin
        if (m_part.size() != 0) m_align = 1'b1;
        m_part.delete();
        m_part.push_back(s);
      end else if (m_part.size() != 0) begin
        m_part.push_back(s);
      end
      if (m_part.size() == NBITS) begin
        for (int i = 0; i < NBITS; i++) ones += int'(m_part[i]);
        for (int i = 0; i < WIDTH; i++) value = value * 2 + int'(m_part[i]);
        if (!PAR || (ones % 2) == 0) done = 1'b1;
        else m_perr = 1'b1;
        m_part.delete();
      end
    end
    if (done) begin
      if (!m_valid || accept) begin
        m_dout  = WIDTH'(value);
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (accept) begin
      m_valid = 1'b0;
    end
  endfunction

  task automatic step(input bit v, input bit s, input bit st, input bit rdy);
    sin_valid  = v;
    sin        = s;
    sin_start  = st;
    dout_ready = rdy;
    model_step(v, s, st, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit rdy_last, input bit rdy_others);
    logic [WIDTH-1:0] wv;
    wv = w;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      step(1'b1, wv[i], i == WIDTH - 1, (i == 0 && !PAR) ? rdy_last : rdy_others);
    end
    if (PAR) step(1'b1, ^wv, 1'b0, rdy_last);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    n_checks++;
    if ({dout, dout_valid, overrun, align_err, parity_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: dout=%h valid=%b ovr=%b align=%b perr=%b, required all 0",
               dout, dout_valid, overrun, align_err, parity_err);
    end
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dout_valid !== 1'b0 || dout !== '0) begin
      n_fail++;
      $display("FAIL reset_midword: dout=%h valid=%b, required 0/0", dout, dout_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hunt: valid=%b, required 0", dout_valid);
    end
  endtask

  task automatic test_basic();
    send_word(4'hB, 1'b1, 1'b1);
    n_checks++;
    if (dout_valid !== 1'b1 || dout !== 4'hB) begin
      n_fail++;
      $display("FAIL basic_word: dout=%h valid=%b, required B/1", dout, dout_valid);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain: valid=%b, required 0", dout_valid);
    end
  endtask

  task automatic test_overrun();
    send_word(4'hB, 1'b0, 1'b0);
    send_word(4'h6, 1'b0, 1'b0);
    n_checks++;
    if (overrun !== 1'b1 || dout !== 4'hB || dout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_pulse: ovr=%b dout=%h valid=%b, required 1/B/1", overrun, dout, dout_valid);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (overrun !== 1'b0 || dout !== 4'hB) begin
      n_fail++;
      $display("FAIL overrun_once: ovr=%b dout=%h, required 0/B", overrun, dout);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_nosecond: valid=%b, required 0", dout_valid);
    end
  endtask

  task automatic test_align();
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (align_err !== 1'b1) begin
      n_fail++;
      $display("FAIL align_pulse: align=%b, required 1", align_err);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (align_err !== 1'b0) begin
      n_fail++;
      $display("FAIL align_once: align=%b, required 0", align_err);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    if (PAR) step(1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (dout !== 4'h5 || dout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL align_word: dout=%h valid=%b, required 5/1", dout, dout_valid);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    send_word(4'hB, 1'b0, 1'b0);
    send_word(4'h6, 1'b1, 1'b0);
    n_checks++;
    if (overrun !== 1'b0 || dout !== 4'h6 || dout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle: ovr=%b dout=%h valid=%b, required 0/6/1", overrun, dout, dout_valid);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_drain: valid=%b, required 0", dout_valid);
    end
  endtask

`ifdef SIPO_PARITY_EN
  task automatic test_parity();
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (dout !== 4'hB || dout_valid !== 1'b1 || parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_good: dout=%h valid=%b perr=%b, required B/1/0", dout, dout_valid, parity_err);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (parity_err !== 1'b1 || dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_bad: perr=%b valid=%b, required 1/0", parity_err, dout_valid);
    end
  endtask
`endif

  task automatic test_random();
    bit v, s, st, rdy;
    for (int c = 0; c < 500; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 5) == 0);
      s   = 1'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      step(v, s, st, rdy);
      n_checks++;
      if (dout_valid !== m_valid || (m_valid && dout !== m_dout) || overrun !== m_ovr ||
          align_err !== m_align || parity_err !== m_perr) begin
        n_fail++;
        $display("FAIL random_cycle %0d: dout=%h valid=%b ovr=%b align=%b perr=%b, required %h/%b/%b/%b/%b",
                 c, dout, dout_valid, overrun, align_err, parity_err,
                 m_dout, m_valid, m_ovr, m_align, m_perr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_align();
    test_back_to_back();
`ifdef SIPO_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
